tick_timer: RTL and testbench
=============================

TICK_TIMER -- requirements
Module: tick_timer

Interface
REQ-001 Parameter WIDTH, default 16, width of load value and remaining count.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset; while high, all state is forced to reset values.
REQ-004 tick  input  1  single-cycle timebase pulse from the upstream tick counter; one decrement per high cycle.
REQ-005 start  input  1  single-cycle command: capture load_val and mode, then begin counting.
REQ-006 stop  input  1  single-cycle command: abort counting.
REQ-007 mode  input  1  sampled with start: 0 = one-shot, 1 = periodic.
REQ-008 load_val  input  WIDTH  tick count per period; sampled only when start is accepted.
REQ-009 busy  output  1  high while the FSM is in RUN.
REQ-010 remaining  output  WIDTH  ticks left in the current period.
REQ-011 expired  output  1  single-cycle pulse at each period end.
REQ-012 err  output  1  single-cycle pulse when start is rejected.
REQ-013 exp_cnt  output  8  count of expirations since the last accepted start; wraps 255 -> 0.

Function
REQ-014 The FSM SHALL have exactly two states, IDLE and RUN, and all outputs SHALL be registered.
REQ-015 Start acceptance:
- start=1, stop=0, load_val!=0, in any state: next state RUN.
- Same edge: shadow <= load_val, remaining <= load_val, mode latched, exp_cnt <= 0.
REQ-016 Start rejection: start=1, stop=0, load_val==0.
- err high for the following cycle.
- State, remaining, mode and exp_cnt unchanged.
REQ-017 A tick sampled on the same edge as an accepted start SHALL be ignored; the first decrement occurs on the next tick.
REQ-018 In RUN, with tick=1 and no start or stop, remaining SHALL decrement by 1 when remaining > 1.
REQ-019 Period end: in RUN, tick=1, remaining==1, no start or stop, on that edge:
- expired <= 1 for one cycle.
- exp_cnt <= exp_cnt + 1 (mod 256).
REQ-020 At period end in one-shot mode: remaining <= 0 and next state IDLE.
REQ-021 At period end in periodic mode: remaining <= shadow and state stays RUN, so expired repeats exactly every shadow ticks.
REQ-022 Stop:
- stop=1 forces IDLE and holds remaining at its current value.
- No expired pulse; exp_cnt held.
- stop wins over a simultaneous start and over a simultaneous tick.
REQ-023 start while in RUN SHALL restart counting: reload from the new load_val and clear exp_cnt; an expiry that would have occurred on that edge is suppressed.
REQ-024 In IDLE, tick SHALL have no effect on any state or output.
REQ-025 Each tick-high cycle SHALL produce at most one decrement; tick held high for N cycles counts as N ticks.
REQ-026 busy SHALL equal (state == RUN) and is low in the cycle after one-shot expiry.
REQ-027 Counter arithmetic SHALL be WIDTH-bit unsigned; remaining never underflows below 0.

Reset
REQ-028 While rst=1, outputs SHALL be: busy=0, remaining=0, expired=0, err=0, exp_cnt=0.
REQ-029 While rst=1, internal state SHALL be: state=IDLE, shadow=0, mode=0.
REQ-030 Reset asserted mid-RUN SHALL abort immediately with no expired pulse; after release the block stays IDLE until a new start.

Verification
REQ-031 One-shot, load_val=3, ticks every 1000 cycles -> remaining 3,2,1,0; expired once on the third tick edge; busy low afterwards; exp_cnt=1.
REQ-032 Periodic, load_val=2, 7 ticks -> expired on ticks 2, 4 and 6; remaining=1 after the seventh tick; exp_cnt=3; busy stays high.
REQ-033 start with load_val=0 -> err pulse for 1 cycle; busy=0; remaining unchanged.
REQ-034 Collisions:
- start+tick same cycle, load_val=5 -> remaining=5, not 4.
- stop+tick with remaining=1 -> no expired; remaining=1; IDLE.
REQ-035 rst pulse while RUN with remaining=4 -> all outputs 0 during reset; no expired; ticks after release ignored.
REQ-036 Periodic, load_val=1, tick held high for 300 cycles -> expired high for 300 consecutive cycles; exp_cnt wraps to 44.

Source files
------------

// File: rtl/tick_timer.sv
// rtl/tick_timer.sv - tick-driven one-shot/periodic countdown timer with expiry counter
module tick_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] load_val,
    output logic             busy,
    output logic [WIDTH-1:0] remaining,
    output logic             expired,
    output logic             err,
    output logic [7:0]       exp_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic             periodic;

    // busy is taken straight from the state flop, so it stays registered
    assign busy = (state == RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shadow    <= '0;
            periodic  <= 1'b0;
            remaining <= '0;
            expired   <= 1'b0;
            err       <= 1'b0;
            exp_cnt   <= 8'd0;
        end else begin
            expired <= 1'b0;
            err     <= 1'b0;
            if (stop) begin
                // stop freezes remaining and overrides both start and tick
                state <= IDLE;
            end else if (start) begin
                if (load_val != '0) begin
                    state     <= RUN;
                    shadow    <= load_val;
                    remaining <= load_val;
                    periodic  <= mode;
                    exp_cnt   <= 8'd0;
                end else begin
                    err <= 1'b1;
                end
            end else if (state == RUN && tick) begin
                if (remaining > ONE) begin
                    remaining <= remaining - ONE;
                end else if (remaining == ONE) begin
                    expired <= 1'b1;
                    exp_cnt <= exp_cnt + 8'd1;
                    if (periodic) begin
                        remaining <= shadow;
                    end else begin
                        remaining <= '0;
                        state     <= IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_tick_timer.sv
// tb/tb_tick_timer.sv - directed scoreboard bench for tick_timer
module tb_tick_timer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         tick = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         busy;
    logic [W-1:0] remaining;
    logic         expired;
    logic         err;
    logic [7:0]   exp_cnt;

    tick_timer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .start     (start),
        .stop      (stop),
        .mode      (mode),
        .load_val  (load_val),
        .busy      (busy),
        .remaining (remaining),
        .expired   (expired),
        .err       (err),
        .exp_cnt   (exp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         b;
        logic [W-1:0] r;
        logic         e;
        logic         er;
        logic [7:0]   c;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];
    int    n_assert = 0;
    int    n_fail   = 0;

    task automatic cmp(input string tag, input string field,
                       input logic [W-1:0] got, input logic [W-1:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, field, got, want);
        end
    endtask

    task automatic push(input string tag, input logic b, input logic [W-1:0] r,
                        input logic e, input logic er, input logic [7:0] c);
        exp_t x;
        x.b = b; x.r = r; x.e = e; x.er = er; x.c = c;
        sb.push_back(x);
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        exp_t  x;
        string t;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end else begin
            x = sb.pop_front();
            t = tag_q.pop_front();
            cmp(t, "busy",      W'(busy),    W'(x.b));
            cmp(t, "remaining", remaining,   x.r);
            cmp(t, "expired",   W'(expired), W'(x.e));
            cmp(t, "err",       W'(err),     W'(x.er));
            cmp(t, "exp_cnt",   W'(exp_cnt), W'(x.c));
        end
    endtask

    // drive inputs away from the edge, expect after the next rising edge
    task automatic step(input logic s, input logic p, input logic t, input logic m,
                        input logic [W-1:0] lv, input string tag,
                        input logic b, input logic [W-1:0] r, input logic e,
                        input logic er, input logic [7:0] c);
        @(negedge clk);
        start = s; stop = p; tick = t; mode = m; load_val = lv;
        push(tag, b, r, e, er, c);
        @(posedge clk);
        #1;
        check_now();
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        push("reset", 1'b0, 16'd0, 1'b0, 1'b0, 8'd0);
        check_now();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 16'd0, "idle_tick_after_reset", 0, 16'd0, 0, 0, 8'd0);

        // one-shot, load 3, tick every 1000 cycles
        step(1, 0, 0, 0, 16'd3, "os_start", 1, 16'd3, 0, 0, 8'd0);
        for (int k = 1; k <= 3; k++) begin
            for (int i = 0; i < 999; i++)
                step(0, 0, 0, 0, 16'd0, "os_wait", 1, 16'(4 - k), 0, 0, 8'd0);
            if (k < 3)
                step(0, 0, 1, 0, 16'd0, "os_tick", 1, 16'(3 - k), 0, 0, 8'd0);
            else
                step(0, 0, 1, 0, 16'd0, "os_expire", 0, 16'd0, 1, 0, 8'd1);
        end
        step(0, 0, 0, 0, 16'd0, "os_after", 0, 16'd0, 0, 0, 8'd1);

        // rejected start
        step(1, 0, 0, 1, 16'd0, "reject", 0, 16'd0, 0, 1, 8'd1);
        step(0, 0, 0, 0, 16'd0, "reject_after", 0, 16'd0, 0, 0, 8'd1);

        // periodic, load 2, seven ticks
        step(1, 0, 0, 1, 16'd2, "per_start", 1, 16'd2, 0, 0, 8'd0);
        for (int k = 1; k <= 7; k++) begin
            if (k % 2 == 0)
                step(0, 0, 1, 0, 16'd0, "per_expire", 1, 16'd2, 1, 0, 8'(k / 2));
            else
                step(0, 0, 1, 0, 16'd0, "per_tick", 1, 16'd1, 0, 0, 8'(k / 2));
        end
        step(0, 0, 0, 0, 16'd0, "per_hold", 1, 16'd1, 0, 0, 8'd3);

        // stop with tick at remaining 1, then tick in IDLE
        step(0, 1, 1, 0, 16'd0, "stop_tick", 0, 16'd1, 0, 0, 8'd3);
        step(0, 0, 1, 0, 16'd0, "idle_tick", 0, 16'd1, 0, 0, 8'd3);

        // start and tick on the same edge
        step(1, 0, 1, 0, 16'd5, "start_tick", 1, 16'd5, 0, 0, 8'd0);
        step(0, 0, 1, 0, 16'd0, "first_dec", 1, 16'd4, 0, 0, 8'd0);
        step(0, 0, 1, 0, 16'd0, "dec3", 1, 16'd3, 0, 0, 8'd0);
        step(0, 0, 1, 0, 16'd0, "dec2", 1, 16'd2, 0, 0, 8'd0);
        step(0, 0, 1, 0, 16'd0, "dec1", 1, 16'd1, 0, 0, 8'd0);
        // restart on what would have been the expiry edge
        step(1, 0, 1, 1, 16'd4, "restart", 1, 16'd4, 0, 0, 8'd0);
        step(1, 1, 0, 0, 16'd9, "stop_beats_start", 0, 16'd4, 0, 0, 8'd0);
        step(1, 0, 0, 0, 16'd4, "restart_os", 1, 16'd4, 0, 0, 8'd0);
        step(1, 0, 1, 0, 16'd0, "reject_in_run", 1, 16'd4, 0, 1, 8'd0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        rst = 1'b1; tick = 1'b1; start = 1'b0;
        #1;
        push("rst_async", 0, 16'd0, 0, 0, 8'd0);
        check_now();
        @(posedge clk);
        #1;
        push("rst_held", 0, 16'd0, 0, 0, 8'd0);
        check_now();
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 1, 0, 16'd0, "rst_tick1", 0, 16'd0, 0, 0, 8'd0);
        step(0, 0, 1, 0, 16'd0, "rst_tick2", 0, 16'd0, 0, 0, 8'd0);

        // periodic load 1 with tick held high: expires every cycle, counter wraps
        step(1, 0, 0, 1, 16'd1, "p1_start", 1, 16'd1, 0, 0, 8'd0);
        for (int k = 1; k <= 300; k++)
            step(0, 0, 1, 0, 16'd0, "p1_tick", 1, 16'd1, 1, 0, 8'(k % 256));
        step(0, 0, 0, 0, 16'd0, "p1_end", 1, 16'd1, 0, 0, 8'd44);
        step(0, 1, 0, 0, 16'd0, "p1_stop", 0, 16'd1, 0, 0, 8'd44);

        if (sb.size() != 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
